// File: rtl/pipelined_addsub_unit.sv
// Slice-pipelined two's-complement adder/subtractor: S = N/K stages each resolve one
// K-bit slice and hand the carry on; the output register adds carry/borrow, overflow and zero flags.
module pipelined_addsub_unit #(
  parameter int N = 16,
  parameter int K = 4
) (
  input  logic         clk,
  input  logic         nrst,
  input  logic         en,
  input  logic         in_valid,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         addsub,
  output logic         out_valid,
  output logic [N-1:0] SUM,
  output logic         cout,
  output logic         ovf,
  output logic         zero
);
  localparam int S = N / K;

  if (N < 2 || (N % K) != 0) begin : g_param_check
    $error("pipelined_addsub_unit: N must be >= 2 and a multiple of K");
  end

  // Handshake: a result is delivered on an edge where en = 1 and out_valid = 1;
  // en = 0 freezes every register, so out_valid must be qualified with en downstream.

  // Index 0 is the input register; index i holds the state after slice i-1 is resolved.
  // r_q starts as operand A and has its slices replaced by sum bits as they resolve.
  logic         v_q   [0:S];
  logic         sub_q [0:S];
  logic         sa_q  [0:S];
  logic         sb_q  [0:S];
  logic         c_q   [0:S];
  logic [N-1:0] r_q   [0:S];
  logic [N-1:0] b_q   [0:S-1];

  logic         c_d [1:S];
  logic [N-1:0] r_d [1:S];
  logic [N-1:0] bp;

  assign bp = addsub ? ~B : B;

  always_comb begin
    logic [K:0] t;
    t = '0;
    for (int i = 1; i <= S; i++) begin
      t = {1'b0, r_q[i-1][(i-1)*K +: K]} + {1'b0, b_q[i-1][(i-1)*K +: K]}
        + {{K{1'b0}}, c_q[i-1]};
      r_d[i] = r_q[i-1];
      r_d[i][(i-1)*K +: K] = t[K-1:0];
      c_d[i] = t[K];
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int i = 0; i <= S; i++) begin
        v_q[i]   <= 1'b0;
        sub_q[i] <= 1'b0;
        sa_q[i]  <= 1'b0;
        sb_q[i]  <= 1'b0;
        c_q[i]   <= 1'b0;
        r_q[i]   <= '0;
      end
      for (int i = 0; i < S; i++) b_q[i] <= '0;
      out_valid <= 1'b0;
      SUM       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
      zero      <= 1'b0;
    end else if (en) begin
      v_q[0]   <= in_valid;
      sub_q[0] <= addsub;
      sa_q[0]  <= A[N-1];
      sb_q[0]  <= bp[N-1];
      c_q[0]   <= addsub;
      r_q[0]   <= A;
      b_q[0]   <= bp;
      for (int i = 1; i <= S; i++) begin
        v_q[i]   <= v_q[i-1];
        sub_q[i] <= sub_q[i-1];
        sa_q[i]  <= sa_q[i-1];
        sb_q[i]  <= sb_q[i-1];
        c_q[i]   <= c_d[i];
        r_q[i]   <= r_d[i];
      end
      for (int i = 1; i < S; i++) b_q[i] <= b_q[i-1];
      // Bubbles only clear out_valid; the data flags keep the last real result.
      out_valid <= v_q[S];
      if (v_q[S]) begin
        SUM  <= r_q[S];
        cout <= sub_q[S] ^ c_q[S];
        ovf  <= (sa_q[S] == sb_q[S]) && (r_q[S][N-1] != sa_q[S]);
        zero <= ~|r_q[S];
      end
    end
  end

endmodule

// File: doc/pipelined_addsub_unit.md
# pipelined_addsub_unit

Parametrised, slice-pipelined two's-complement adder/subtractor with a valid/stall flow-control wrapper and status flags. Operands are split into K-bit slices. Each pipeline stage resolves one slice and passes its carry to the next, so clock rate is set by a K-bit ripple rather than an N-bit one. The unit accepts one operation per cycle and sits between the operand-issue logic and the result writeback in the arithmetic datapath.

## Interface
- N, default 16: operand and result width in bits; N ≥ 2.
- K, default 4: bits resolved per pipeline stage; N mod K must be 0, otherwise elaboration fails. S = N/K stages.

- clk  in  1  rising-edge clock; the only clock.
- nrst  in  1  reset, asynchronous, active-low.
- en  in  1  pipeline advance; 0 freezes every register, including outputs.
- in_valid  in  1  an operation is presented this cycle.
- A  in  N  operand A.
- B  in  N  operand B.
- addsub  in  1  0 = A+B, 1 = A−B.
- out_valid  out  1  SUM and flags carry a new result.
- SUM  out  N  result modulo 2^N.
- cout  out  1  add: carry out; sub: borrow (inverted carry).
- ovf  out  1  signed two's-complement overflow.
- zero  out  1  SUM == 0.

## Operation
- Stage 0 (input register):
  - Captures A.
  - Captures B' = addsub ? ~B : B.
  - Sets cin = addsub.
  - Captures in_valid and addsub.
  - Captures the sign bits A[N−1] and B'[N-1] for the overflow check.
- Stage i (1..S):
  - Adds slice i−1 ([iK−1:(i−1)K]) of A and B' with the carry from stage i−1 (cin for stage 1).
  - Registers the K sum bits and the carry out.
  - All other slices, valid, addsub and sign bits ride alongside, unchanged.
- Output register, loaded from stage S:
  - SUM = the assembled slices.
  - cout = addsub ? ~c_S : c_S.
  - ovf = (A[N−1] == B'[N−1]) && (SUM[N−1] != A[N−1]).
  - zero = ~|SUM.
  - out_valid = valid bit of stage S.
- Bubbles (valid = 0) propagate like operations. When a bubble reaches the output register, out_valid drops to 0 and SUM, cout, ovf, zero hold their previous values.
- en = 0: no register changes, and out_valid holds its value. Downstream must qualify out_valid with en; a result is consumed exactly once, on an edge with en = 1.
- No state machine. Pipeline state is the per-stage valid bits only.

## Timing
- Reset:
  - nrst low clears, immediately and without waiting for clk, every pipeline register, out_valid, SUM, cout, ovf and zero (all 0).
  - Any in-flight operations are discarded.
  - The first edge with nrst high may sample a new operation.
- Latency: an operation sampled at edge k (in_valid = 1, en = 1) appears on the outputs after edge k+S+1, counting only edges with en = 1. Default configuration: 5 edges.
- Throughput: one operation per enabled cycle, with no dead cycles between back-to-back operations. Results leave in issue order.
- en stall: if en is low for M cycles, latency stretches by exactly M. No result is lost, duplicated or reordered.
- Degenerate widths:
  - K = N: S = 1, latency 2.
  - K = 1: S = N, latency N+1.
- Simultaneous en = 0 and in_valid = 1: the operand is not sampled. The issuer must hold it until en = 1.

## Test plan
- Add, N=16, K=4: 0x1234 + 0x0001 → 5 enabled edges later, out_valid=1 for one cycle, SUM=0x1235, cout=0, ovf=0, zero=0.
- Subtract: 0x0005 − 0x0007 → SUM=0xFFFE, cout=1 (borrow), ovf=0. Then 0x8000 − 0x0001 → SUM=0x7FFF, cout=0, ovf=1.
- Add boundaries:
  - 0x7FFF + 0x0001 → SUM=0x8000, ovf=1, cout=0.
  - 0xFFFF + 0x0001 → SUM=0x0000, cout=1, zero=1, ovf=0.
- Streaming:
  - 64 random operations with in_valid pattern 1,1,0,1,0,0,1… and random addsub.
  - Every result matches the reference model, in order, with the valid pattern reproduced after exactly 5 edges.
  - Repeat at K=1 (latency 17) and K=16 (latency 2).
- Stall: en=0 for 3 cycles mid-stream → all outputs frozen. After en returns, the remaining results arrive 3 cycles later than unstalled timing, with none missing or duplicated.
- Reset:
  - Assert nrst between clock edges while 4 operations are in flight → out_valid, SUM, cout, ovf, zero read 0 before the next edge.
  - After release, no stale result ever appears.
  - The first new operation completes with normal latency.
